calculator_top: RTL and testbench
=================================

Name:
calculator_top

Overview:
- Top-level 4-bit calculator for a board with two 4-bit switch banks, four push buttons and a 4-digit multiplexed seven-segment display.
- The user selects an operation with up/down and latches the result with enter; back returns to selection.
- Buttons are debounced and edge-detected internally.
- The block drives the anode and segment pins directly.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles before a button level is accepted.
- REFRESH_CYCLES, 4096: cycles each digit is lit before the scan advances.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- a, in, 4: operand A, unsigned.
- b, in, 4: operand B, unsigned.
- enter, in, 1: raw button, compute and show result.
- back, in, 1: raw button, return to operation select.
- up, in, 1: raw button, next operation.
- down, in, 1: raw button, previous operation.
- an, out, 4: digit anodes, active-low; an[0] is the rightmost digit.
- seg, out, 8: active-low segments; seg[0]=a … seg[6]=g, seg[7]=dp (dp always off, driven 1).

Behaviour:
- Reset, while rst=1 at a clock edge:
  - state=SELECT, op=0, result=0.
  - Debouncers cleared to the "released" level; scan counter=0.
  - an=4'b1111, seg=8'hFF.
- Debounce, per button:
  - Accept a new level only after the raw input differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch reset to agreement restarts the count.
  - A rising edge of the accepted level produces a 1-cycle pulse.
  - Releasing a button produces no pulse.
  - Holding a button produces exactly one pulse.
- Simultaneous pulses in the same cycle: priority back > enter > up > down; lower-priority pulses in that cycle are dropped.
- Operations (op, 3-bit):
  - 0 ADD: a+b.
  - 1 SUB: |a-b|, neg flag set when a<b.
  - 2 MUL: a*b.
  - 3 DIV: a/b.
  - 4 MOD: a%b.
  - 5 AND.
  - 6 OR.
  - 7 XOR.
  - Result is 8 bits, zero-extended.
- DIV/MOD with b=0: err flag set, result=0.
- SELECT state:
  - up: op=op+1, wrapping 7→0.
  - down: op=op-1, wrapping 0→7.
  - enter: sample a and b in that cycle, register result/neg/err, go to RESULT.
  - Result is valid on the display the cycle after the enter pulse.
  - back: ignored.
- RESULT state:
  - Result held even if a/b change.
  - up, down and enter are ignored.
  - back: go to SELECT, op unchanged.
- Display in SELECT: digit3=hex(a), digit2=hex(b), digit1=blank, digit0=op (0-7). Display follows the live switches.
- Display in RESULT:
  - digit3 = '-' (g only) if neg, else blank.
  - digit2 = op.
  - digit1:0 = result in hex.
- Display when err: digits3..0 = blank, E, r, r.
- Segment patterns (active-low g..a):
  - Hex digits 0-F use the standard glyphs; b, c, d, r are lowercase.
  - blank=7'h7F.
  - '-'=7'h3F.
  - E=7'h06.
  - r=7'h2F.
- Scan:
  - After reset the active digit cycles 0→1→2→3→0.
  - Each digit is held for REFRESH_CYCLES cycles.
  - Exactly one anode is low at any time after reset.
  - seg always carries the pattern for the currently lit digit.
- Reset mid-operation (any state, any debounce count): returns everything to the reset values above.
- A held button across reset release does not generate a pulse until it has been released and pressed again.

Test Plan:
- Reset then idle, a=10, b=15 → SELECT, op=0; scanning shows A, F, blank, 0; never more than one anode low.
- Six debounced up presses, each held ≥ DEBOUNCE_CYCLES, then enter with a=10, b=15 → op=6 (OR), RESULT shows blank, 6, 0, F.
- From op=0, one down press → op=7; one more up press → op=0 (wrap both directions).
- op=1, a=3, b=9, enter → RESULT shows '-', 1, 0, 6; back → SELECT with op still 1.
- op=3, b=0, enter → displays blank, E, r, r; op=2, a=15, b=15 → result E1.
- Glitches on up shorter than DEBOUNCE_CYCLES → op unchanged.
- up and down pressed in the same cycle → op increments only.
- rst asserted in RESULT → SELECT, op=0.

Source files
------------

// File: rtl/calculator_top.sv
// calculator_top -- 4-bit calculator for a two-switch-bank, four-button,
// 4-digit multiplexed seven-segment board.
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   a, b [3:0]      unsigned operands from the switch banks
//   enter           raw button: compute and show the result
//   back            raw button: return to operation select
//   up, down        raw buttons: next / previous operation
//   an  [3:0]       digit anodes, active-low, an[0] = rightmost digit
//   seg [7:0]       segments, active-low, seg[0]=a .. seg[6]=g, seg[7]=dp (off)
//
// Parameters:
//   DEBOUNCE_CYCLES consecutive disagreeing cycles before a button level is accepted
//   REFRESH_CYCLES  cycles each digit stays lit before the scan advances
module calculator_top #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REFRESH_CYCLES  = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       enter,
  input  logic       back,
  input  logic       up,
  input  logic       down,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYCLES - 1);

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_R     = 7'h2F;

  typedef enum logic {SELECT, RESULT} state_t;

  // Active-low g..a glyphs; b, c, d are the lowercase forms.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h27;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] abs_diff(input logic signed [4:0] d);
    logic signed [4:0] m;
    m = (d < 0) ? -d : d;
    return {3'b000, m};
  endfunction

  // ---- stage p0: button debounce and edge detect ----
  // Bit order: 0 up, 1 down, 2 enter, 3 back.
  logic [3:0]    raw_p0;
  logic [3:0]    level_p0;
  logic [3:0]    armed_p0;
  logic [3:0]    pulse_p0;
  logic [DW-1:0] db_cnt_p0 [4];

  assign raw_p0 = {back, enter, down, up};

  // armed is cleared by reset and only set once the button is seen released,
  // so a button held through reset cannot fire until pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_p0 <= '0;
      armed_p0 <= '0;
      pulse_p0 <= '0;
      for (int i = 0; i < 4; i++) db_cnt_p0[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pulse_p0[i] <= 1'b0;
        if (raw_p0[i] != level_p0[i]) begin
          if (db_cnt_p0[i] == DB_LAST) begin
            level_p0[i]  <= raw_p0[i];
            db_cnt_p0[i] <= '0;
            pulse_p0[i]  <= raw_p0[i] & armed_p0[i];
          end else begin
            db_cnt_p0[i] <= db_cnt_p0[i] + 1'b1;
          end
        end else begin
          db_cnt_p0[i] <= '0;
          if (!level_p0[i]) armed_p0[i] <= 1'b1;
        end
      end
    end
  end

  // Priority back > enter > up > down; losers in the same cycle are dropped.
  logic back_p1, enter_p1, up_p1, down_p1;
  assign back_p1  = pulse_p0[3];
  assign enter_p1 = pulse_p0[2] & ~pulse_p0[3];
  assign up_p1    = pulse_p0[0] & ~(|pulse_p0[3:2]);
  assign down_p1  = pulse_p0[1] & ~(|pulse_p0[3:2]) & ~pulse_p0[0];

  // ---- stage p1: ALU, control FSM and result register ----
  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        load_p1;
  logic [7:0]  alu_p1;
  logic        alu_neg_p1, alu_err_p1;
  logic signed [4:0] diff_p1;
  logic [7:0]  result_p2;
  logic        neg_p2, err_p2;

  assign diff_p1 = $signed({1'b0, a}) - $signed({1'b0, b});

  always_comb begin
    alu_p1     = '0;
    alu_neg_p1 = 1'b0;
    alu_err_p1 = 1'b0;
    case (op_q)
      3'd0: alu_p1 = {4'b0, a} + {4'b0, b};
      3'd1: begin
        alu_p1     = abs_diff(diff_p1);
        alu_neg_p1 = diff_p1 < 0;
      end
      3'd2: alu_p1 = {4'b0, a} * {4'b0, b};
      3'd3: if (b == 4'd0) alu_err_p1 = 1'b1; else alu_p1 = {4'b0, a / b};
      3'd4: if (b == 4'd0) alu_err_p1 = 1'b1; else alu_p1 = {4'b0, a % b};
      3'd5: alu_p1 = {4'b0, a & b};
      3'd6: alu_p1 = {4'b0, a | b};
      default: alu_p1 = {4'b0, a ^ b};
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    load_p1 = 1'b0;
    case (state_q)
      SELECT: begin
        if (enter_p1) begin
          load_p1 = 1'b1;
          state_d = RESULT;
        end else if (up_p1) begin
          op_d = op_q + 3'd1;
        end else if (down_p1) begin
          op_d = op_q - 3'd1;
        end
      end
      default: begin
        if (back_p1) state_d = SELECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SELECT;
      op_q      <= '0;
      result_p2 <= '0;
      neg_p2    <= 1'b0;
      err_p2    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (load_p1) begin
        result_p2 <= alu_p1;
        neg_p2    <= alu_neg_p1;
        err_p2    <= alu_err_p1;
      end
    end
  end

  // ---- stage p2: digit scan and segment drive ----
  logic [RW-1:0] rf_cnt_p2;
  logic [1:0]    digit_p2;
  logic          scan_on_p2;
  logic [6:0]    glyph_p2 [4];

  // scan_on keeps all anodes dark until the first clock edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_cnt_p2  <= '0;
      digit_p2   <= '0;
      scan_on_p2 <= 1'b0;
    end else begin
      scan_on_p2 <= 1'b1;
      if (rf_cnt_p2 == RF_LAST) begin
        rf_cnt_p2 <= '0;
        digit_p2  <= digit_p2 + 2'd1;
      end else begin
        rf_cnt_p2 <= rf_cnt_p2 + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) glyph_p2[i] = G_BLANK;
    if (state_q == SELECT) begin
      glyph_p2[3] = hex7(a);
      glyph_p2[2] = hex7(b);
      glyph_p2[0] = hex7({1'b0, op_q});
    end else if (err_p2) begin
      glyph_p2[2] = G_E;
      glyph_p2[1] = G_R;
      glyph_p2[0] = G_R;
    end else begin
      glyph_p2[3] = neg_p2 ? G_DASH : G_BLANK;
      glyph_p2[2] = hex7({1'b0, op_q});
      glyph_p2[1] = hex7(result_p2[7:4]);
      glyph_p2[0] = hex7(result_p2[3:0]);
    end
  end

  assign an  = scan_on_p2 ? ~(4'b0001 << digit_p2) : 4'hF;
  assign seg = scan_on_p2 ? {1'b1, glyph_p2[digit_p2]} : 8'hFF;

endmodule

// File: tb/tb_calculator_top.sv
// Directed bench for calculator_top with short debounce/refresh periods.
module tb_calculator_top;

  localparam int DEB = 8;
  localparam int REF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = 4'd0, b = 4'd0;
  logic       enter = 1'b0, back = 1'b0, up = 1'b0, down = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q [$];

  localparam logic [7:0] S_BLANK = 8'hFF;
  localparam logic [7:0] S_DASH  = 8'hBF;
  localparam logic [7:0] S_E     = 8'h86;
  localparam logic [7:0] S_R     = 8'hAF;

  calculator_top #(.DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .enter(enter), .back(back),
    .up(up), .down(down), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hx(input int v);
    case (v)
      0: hx = 8'hC0;  1: hx = 8'hF9;  2: hx = 8'hA4;  3: hx = 8'hB0;
      4: hx = 8'h99;  5: hx = 8'h92;  6: hx = 8'h82;  7: hx = 8'hF8;
      8: hx = 8'h80;  9: hx = 8'h90;  10: hx = 8'h88; 11: hx = 8'h83;
      12: hx = 8'hA7; 13: hx = 8'hA1; 14: hx = 8'h86; default: hx = 8'h8E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_display(input logic [7:0] d3, input logic [7:0] d2,
                                input logic [7:0] d1, input logic [7:0] d0);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    exp_q.push_back(d3);
  endtask

  // Waits for each digit in turn to be lit and compares it with the scoreboard.
  task automatic check_display(input string tag);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] want_an;
      logic [7:0] exp;
      bit         seen;
      want_an = ~(4'b0001 << k);
      exp     = exp_q.pop_front();
      seen    = 1'b0;
      for (int c = 0; c < 8 * REF + 4 && !seen; c++) begin
        @(negedge clk);
        if (an === want_an) seen = 1'b1;
      end
      if (seen) begin
        chk($sformatf("%s_d%0d", tag, k), seg, exp);
      end else begin
        total++;
        $error("FAIL %s_d%0d_timeout: observed an=%b expected an=%b", tag, k, an, want_an);
      end
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: up = v;
      1: down = v;
      2: enter = v;
      default: back = v;
    endcase
  endtask

  task automatic press(input int idx);
    @(negedge clk);
    set_btn(idx, 1'b1);
    repeat (DEB + 3) @(negedge clk);
    set_btn(idx, 1'b0);
    repeat (DEB + 3) @(negedge clk);
  endtask

  initial begin
    int bad;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_an", {4'b0, an}, 8'h0F);
    chk("rst_seg", seg, 8'hFF);
    a = 4'd10; b = 4'd15;
    rst = 1'b0;

    // Idle SELECT, op 0; exactly one anode low throughout.
    expect_display(hx(10), hx(15), S_BLANK, hx(0));
    check_display("idle");
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ($countones(~an) != 1) bad++;
    end
    chk("onehot", 8'(bad), 8'd0);

    // Wrap both directions.
    press(1);
    expect_display(hx(10), hx(15), S_BLANK, hx(7));
    check_display("down_wrap");
    press(0);
    expect_display(hx(10), hx(15), S_BLANK, hx(0));
    check_display("up_wrap");

    // Six ups to OR, then enter.
    for (int i = 0; i < 6; i++) press(0);
    expect_display(hx(10), hx(15), S_BLANK, hx(6));
    check_display("op6");
    press(2);
    expect_display(S_BLANK, hx(6), hx(0), hx(15));
    check_display("or");
    press(3);

    // SUB with a<b; result held while switches move; back keeps op.
    for (int i = 0; i < 3; i++) press(0);
    a = 4'd3; b = 4'd9;
    press(2);
    expect_display(S_DASH, hx(1), hx(0), hx(6));
    check_display("sub_neg");
    a = 4'd12;
    press(0);
    expect_display(S_DASH, hx(1), hx(0), hx(6));
    check_display("sub_hold");
    press(3);
    expect_display(hx(12), hx(9), S_BLANK, hx(1));
    check_display("back_op1");

    // DIV by zero, then MUL 15*15.
    press(0); press(0);
    b = 4'd0;
    press(2);
    expect_display(S_BLANK, S_E, S_R, S_R);
    check_display("div0");
    press(3);
    press(1);
    a = 4'd15; b = 4'd15;
    press(2);
    expect_display(S_BLANK, hx(2), hx(14), hx(1));
    check_display("mul");
    press(3);

    // Short glitches on up are ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      up = 1'b1;
      repeat (DEB - 2) @(negedge clk);
      up = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (DEB + 3) @(negedge clk);
    expect_display(hx(15), hx(15), S_BLANK, hx(2));
    check_display("glitch");

    // up and down together: up wins.
    @(negedge clk);
    up = 1'b1; down = 1'b1;
    repeat (DEB + 3) @(negedge clk);
    up = 1'b0; down = 1'b0;
    repeat (DEB + 3) @(negedge clk);
    expect_display(hx(15), hx(15), S_BLANK, hx(3));
    check_display("updown");

    // DIV 15/15 then reset from RESULT.
    press(2);
    expect_display(S_BLANK, hx(3), hx(0), hx(1));
    check_display("div");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_an", {4'b0, an}, 8'h0F);
    chk("rst2_seg", seg, 8'hFF);
    rst = 1'b0;
    expect_display(hx(15), hx(15), S_BLANK, hx(0));
    check_display("after_rst");

    // Button held across reset release must not fire until re-pressed.
    @(negedge clk);
    up = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3 * DEB + 5) @(negedge clk);
    expect_display(hx(15), hx(15), S_BLANK, hx(0));
    check_display("held_rst");
    up = 1'b0;
    repeat (DEB + 3) @(negedge clk);
    press(0);
    expect_display(hx(15), hx(15), S_BLANK, hx(1));
    check_display("repress");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
